pad_strip_loader: RTL and testbench
===================================

# pad_strip_loader

Write-side feeder for the 3x3 window memory. Accepts a raw 8-bit pixel stream for one strip of STRIP_H rows by IMG_W columns and writes it into the padded strip buffer. The padded buffer is (IMG_W+2) x (STRIP_H+2) bytes; with the defaults that is 258 x 34 = 8772 bytes. The loader inserts a one-pixel zero border on all four sides, so the window reader can fetch every 3x3 neighbourhood without bounds checks. It emits one buffer write per cycle in strictly ascending address order and pulses `strip_done` when the buffer is complete.

## Interface
- `IMG_W`, 256, raw image width in pixels.
- `STRIP_H`, 32, raw rows per strip.
- `AW`, 14, buffer address width; must satisfy 2^AW >= (IMG_W+2)*(STRIP_H+2).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin loading a strip; sampled only in IDLE.
- `in_valid`  in  1  `in_data` holds a valid raw pixel.
- `in_data`  in  8  raw pixel, row-major, left to right, top to bottom.
- `in_ready`  out  1  loader will accept a pixel this cycle.
- `mem_we`  out  1  buffer write strobe (registered).
- `mem_addr`  out  AW  buffer write address (registered).
- `mem_wdata`  out  8  buffer write data (registered).
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after the last write.
- `strip_done`  out  1  one-cycle pulse after the final write.

## Operation
- States:
  - IDLE: waiting for `start`.
  - TOP: writing padded row 0.
  - LPAD: writing column 0 of a data row.
  - PIX: writing columns 1..IMG_W of a data row.
  - RPAD: writing column IMG_W+1 of a data row.
  - BOT: writing padded row STRIP_H+1.
  - DONE: one cycle, then return to IDLE.
- Counters:
  - row r, 0..STRIP_H+1.
  - col c, 0..IMG_W+1.
  - Write address a = r*(IMG_W+2)+c, kept as an incrementing counter (no multiplier). It starts at 0 and ends at (IMG_W+2)*(STRIP_H+2)-1 = 8772-1 = 8771.
- Transitions:
  - IDLE -> TOP on `start`.
  - TOP -> LPAD after c = IMG_W+1 (IMG_W+2 zero writes).
  - LPAD -> PIX after 1 write.
  - PIX -> RPAD after IMG_W accepted pixels.
  - RPAD -> LPAD if r < STRIP_H; RPAD -> BOT if r = STRIP_H.
  - BOT -> DONE after IMG_W+2 writes.
  - DONE -> IDLE.
- Pad states (TOP, LPAD, RPAD, BOT):
  - Write `mem_wdata` = 0 every cycle, unconditionally.
  - Never assert `in_ready`.
- PIX state:
  - `in_ready` = 1 (decoded from state, combinational).
  - A write occurs only on `in_valid && in_ready`; it writes `in_data` to the current address, then the address and col advance.
  - `in_valid` = 0 stalls the loader: no write, `mem_we` = 0, no counter change.
- Raw pixel p (0..STRIP_H*IMG_W-1) lands at address (p/IMG_W+1)*(IMG_W+2) + (p%IMG_W) + 1.
- Every address is written exactly once, in ascending order. No address is skipped or repeated.
- `start` is ignored in any state other than IDLE. `start` held high in DONE does not start a new strip until IDLE.
- Extra `in_valid` pulses outside PIX are not accepted and have no effect.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `in_ready`, `mem_we`, `busy` and `strip_done` are 0.
  - `mem_addr` and `mem_wdata` are 0.
- Reset asserted mid-strip: at the next edge everything returns to reset values and no further writes occur. A partial buffer is not cleared.
- `start` sampled at edge k -> at edge k+1, `busy` = 1, `mem_we` = 1 and `mem_addr` = 0.
- Pixel handshake at edge k -> `mem_we`/`mem_addr`/`mem_wdata` for that pixel are visible after edge k+1 (one-cycle write latency).
- State change for the pad states takes no bubble cycles: with `in_valid` held high, `mem_we` stays 1 for exactly 8772 consecutive cycles.
- Final write (addr 8771) is visible in cycle n. In cycle n+1: `strip_done` = 1, `busy` = 0, `mem_we` = 0.
- `mem_addr` and `mem_wdata` hold their last value while `mem_we` = 0.

## Test plan
- Reset, then `start` with `in_valid` held high and a ramp pattern (pixel p = p mod 256):
  - exactly 8772 writes, addresses 0..8771 contiguous;
  - addr 259 = 0x00, addr 260 = 0x01, addr 514 = 0xFF;
  - addrs 0..257, 258, 515 and 8514..8771 are all 0;
  - `strip_done` arrives 8773 cycles after `start`.
- Random `in_valid` gaps (~30%):
  - same memory image as the ramp case;
  - `mem_we` = 0 on every PIX-state stall cycle;
  - `in_ready` = 0 throughout all pad columns and pad rows.
- `start` re-asserted mid-strip:
  - no effect, addresses stay contiguous;
  - a second `start` after DONE reloads a new strip from address 0.
- `rst_n` = 0 for 1 cycle at pixel 1000:
  - all outputs return to 0 next cycle;
  - no writes occur until a new `start`, which begins again at address 0.
- `in_valid` = 1 while idle and during TOP:
  - no pixel is consumed;
  - the first accepted pixel writes address 259.
- Parameter check, IMG_W = 4, STRIP_H = 2:
  - 24 writes;
  - pixels land at addresses 7..10 and 13..16; all other addresses are 0.

Source files
------------

// File: rtl/pad_strip_loader_if.sv
// Write-side bus of the padded strip loader: raw pixel stream in, buffer writes and status out.
interface pad_strip_if #(
    parameter int AW = 14
);
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          strip_done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, strip_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, strip_done
    );
endinterface

// File: rtl/pad_strip_loader.sv
// Streams one raw strip into the padded window buffer, adding a one-pixel zero border,
// one write per cycle in ascending address order.
//
// state  | meaning
// IDLE   | waiting for start
// TOP    | zero writes for padded row 0
// LPAD   | zero write for column 0 of a data row
// PIX    | raw pixel writes for columns 1..IMG_W, stalls on !in_valid
// RPAD   | zero write for column IMG_W+1 of a data row
// BOT    | zero writes for padded row STRIP_H+1
// DONE   | strip_done pulse, back to IDLE
module pad_strip_loader #(
    parameter int IMG_W   = 256,
    parameter int STRIP_H = 32,
    parameter int AW      = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    pad_strip_if.slave  bus
);
    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = $clog2(STRIP_H + 2);
    localparam logic [CW-1:0] C_LAST     = CW'(IMG_W + 1);
    localparam logic [CW-1:0] C_PIX_LAST = CW'(IMG_W);
    localparam logic [RW-1:0] R_LAST     = RW'(STRIP_H);
    localparam logic [RW-1:0] R_BOT      = RW'(STRIP_H + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TOP, S_LPAD, S_PIX, S_RPAD, S_BOT, S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_wdata;
    logic          r_busy;
    logic          r_done;

    logic          w_pad;
    logic          w_accept;
    logic          w_wr;
    logic [7:0]    w_wdata;

    // Pad states write every cycle; PIX writes only on a handshake.
    assign w_pad    = (r_state == S_TOP) || (r_state == S_LPAD) ||
                      (r_state == S_RPAD) || (r_state == S_BOT);
    assign w_accept = (r_state == S_PIX) && bus.in_valid;
    assign w_wr     = w_pad || w_accept;
    assign w_wdata  = w_accept ? bus.in_data : 8'h00;

    assign bus.in_ready   = (r_state == S_PIX);
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.strip_done = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_we   <= w_wr;
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
            r_done <= (r_state == S_DONE);
            // Address and data hold their last value on idle/stall cycles.
            if (w_wr) begin
                r_mem_addr <= r_addr;
                r_wdata    <= w_wdata;
                r_addr     <= r_addr + AW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_TOP;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                    end
                end
                S_TOP: begin
                    if (r_col == C_LAST) begin
                        r_col   <= '0;
                        r_row   <= RW'(1);
                        r_state <= S_LPAD;
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                S_LPAD: begin
                    r_col   <= CW'(1);
                    r_state <= S_PIX;
                end
                S_PIX: begin
                    if (w_accept) begin
                        r_col <= r_col + CW'(1);
                        if (r_col == C_PIX_LAST) begin
                            r_state <= S_RPAD;
                        end
                    end
                end
                S_RPAD: begin
                    r_col <= '0;
                    if (r_row == R_LAST) begin
                        r_row   <= R_BOT;
                        r_state <= S_BOT;
                    end else begin
                        r_row   <= r_row + RW'(1);
                        r_state <= S_LPAD;
                    end
                end
                S_BOT: begin
                    if (r_col == C_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pad_strip_loader.sv
// Directed bench for pad_strip_loader: full-size strips plus a 4x2 instance.
module tb_pad_strip_loader;
    localparam int W  = 256;
    localparam int H  = 32;
    localparam int NB = (W + 2) * (H + 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_strip_if #(.AW(14)) bif ();
    pad_strip_if #(.AW(5))  sif ();

    pad_strip_loader #(.IMG_W(W), .STRIP_H(H), .AW(14)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    pad_strip_loader #(.IMG_W(4), .STRIP_H(2), .AW(5)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] img   [NB];
    logic [7:0] s_img [32];
    int n_wr, seq_err, stall_err, hs_err, rdy_err, n_stall, run, max_run, s_nwr;
    bit prev_hs, prev_stall;
    int e1_busy, e1_we, e1_addr, d_busy, d_we;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_pix(input int a);
        int r, c;
        r = a / (W + 2);
        c = a % (W + 2);
        return (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
    endfunction

    function automatic logic [7:0] pat(input int sel, input int p);
        return (sel == 0) ? 8'(p) : 8'(p * 37 + 11);
    endfunction

    function automatic logic [7:0] exp_img(input int sel, input int a);
        int r, c;
        r = a / (W + 2);
        c = a % (W + 2);
        return is_pix(a) ? pat(sel, (r - 1) * W + c - 1) : 8'h00;
    endfunction

    function automatic int bad_count(input int sel);
        int bad = 0;
        for (int a = 0; a < NB; a++)
            if (img[a] !== exp_img(sel, a)) bad++;
        return bad;
    endfunction

    task automatic clear_mon();
        for (int a = 0; a < NB; a++) img[a] = 8'hA5;
        n_wr = 0; seq_err = 0; stall_err = 0; hs_err = 0; rdy_err = 0;
        n_stall = 0; run = 0; max_run = 0;
        prev_hs = 1'b0; prev_stall = 1'b0;
    endtask

    // Called once per negedge: outputs reflect the previous rising edge.
    task automatic mon();
        if (bif.mem_we) begin
            if (int'(bif.mem_addr) != n_wr) seq_err++;
            if (int'(bif.mem_addr) < NB) img[bif.mem_addr] = bif.mem_wdata;
            n_wr++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (prev_stall) n_stall++;
        if (prev_stall && bif.mem_we) stall_err++;
        if (prev_hs && !bif.mem_we) hs_err++;
        if (bif.in_ready !== (bif.busy && is_pix(n_wr))) rdy_err++;
        prev_hs    = rst_n && bif.in_ready && bif.in_valid;
        prev_stall = rst_n && bif.in_ready && !bif.in_valid;
        if (sif.mem_we) begin
            s_img[sif.mem_addr] = sif.mem_wdata;
            s_nwr++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #2;
    endtask

    // Pulses start, then feeds pattern sel until strip_done or stop_p pixels accepted.
    task automatic run_strip(input int sel, input int gap, input bit mid_start,
                             input int stop_p, output int lat, output int p);
        int cyc = 0;
        bit rdy;
        bit seen = 0;
        p   = 0;
        lat = -1;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
        while (cyc < 20000 && !seen && p < stop_p) begin
            bif.in_valid = ($urandom_range(99) >= gap);
            bif.in_data  = pat(sel, p);
            bif.start    = mid_start && (p >= 500) && (p < 504);
            @(negedge clk);
            mon();
            rdy = bif.in_ready;
            if (cyc == 1) begin
                e1_busy = int'(bif.busy); e1_we = int'(bif.mem_we); e1_addr = int'(bif.mem_addr);
            end
            if (bif.strip_done) begin
                seen = 1; lat = cyc;
                d_busy = int'(bif.busy); d_we = int'(bif.mem_we);
            end
            @(posedge clk);
            #2;
            if (rdy && bif.in_valid) p++;
            cyc++;
        end
        bif.start = 1'b0;
    endtask

    initial begin
        int lat, p, wr0, s_bad, sp, scyc;
        bit srdy;
        bif.start = 0; bif.in_valid = 0; bif.in_data = 0;
        sif.start = 0; sif.in_valid = 0; sif.in_data = 0;
        s_nwr = 0;
        for (int a = 0; a < 32; a++) s_img[a] = 8'hA5;
        clear_mon();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_we",    int'(bif.mem_we), 0);
        chk("rst_addr",  int'(bif.mem_addr), 0);
        chk("rst_wdata", int'(bif.mem_wdata), 0);
        chk("rst_busy",  int'(bif.busy), 0);
        chk("rst_done",  int'(bif.strip_done), 0);
        chk("rst_ready", int'(bif.in_ready), 0);

        // Ramp, in_valid held high including idle and TOP.
        clear_mon();
        bif.in_valid = 1'b1;
        repeat (5) tick();
        chk("idle_nowr", n_wr, 0);
        run_strip(0, 0, 0, 1 << 30, lat, p);
        chk("ramp_lat", lat, 8773);
        chk("ramp_nwr", n_wr, 8772);
        chk("ramp_pix", p, 8192);
        chk("ramp_seq", seq_err, 0);
        chk("ramp_run", max_run, 8772);
        chk("ramp_e1_busy", e1_busy, 1);
        chk("ramp_e1_we", e1_we, 1);
        chk("ramp_e1_addr", e1_addr, 0);
        chk("ramp_dn_busy", d_busy, 0);
        chk("ramp_dn_we", d_we, 0);
        chk("ramp_a259", int'(img[259]), 8'h00);
        chk("ramp_a260", int'(img[260]), 8'h01);
        chk("ramp_a514", int'(img[514]), 8'hFF);
        chk("ramp_a258", int'(img[258]), 0);
        chk("ramp_a515", int'(img[515]), 0);
        chk("ramp_a257", int'(img[257]), 0);
        chk("ramp_a8514", int'(img[8514]), 0);
        chk("ramp_a8771", int'(img[8771]), 0);
        chk("ramp_img", bad_count(0), 0);
        chk("ramp_rdy", rdy_err, 0);
        chk("ramp_hs", hs_err, 0);
        chk("done_pulse", int'(bif.strip_done), 0);
        chk("hold_addr", int'(bif.mem_addr), 8771);

        // Random in_valid gaps.
        clear_mon();
        run_strip(0, 30, 0, 1 << 30, lat, p);
        chk("gap_nwr", n_wr, 8772);
        chk("gap_seq", seq_err, 0);
        chk("gap_img", bad_count(0), 0);
        chk("gap_stall_we", stall_err, 0);
        chk("gap_hs", hs_err, 0);
        chk("gap_rdy", rdy_err, 0);
        chk("gap_some_stall", int'(n_stall > 100), 1);
        chk("gap_done_seen", int'(lat > 8773), 1);

        // start re-asserted mid-strip, then a fresh strip after DONE.
        clear_mon();
        run_strip(0, 0, 1, 1 << 30, lat, p);
        chk("mid_lat", lat, 8773);
        chk("mid_nwr", n_wr, 8772);
        chk("mid_seq", seq_err, 0);
        chk("mid_img", bad_count(0), 0);
        clear_mon();
        run_strip(1, 10, 0, 1 << 30, lat, p);
        chk("re_nwr", n_wr, 8772);
        chk("re_seq", seq_err, 0);
        chk("re_img", bad_count(1), 0);

        // Reset mid-strip at pixel 1000.
        clear_mon();
        bif.in_valid = 1'b1;
        run_strip(0, 0, 0, 1000, lat, p);
        chk("rs_pix", p, 1000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_we",    int'(bif.mem_we), 0);
        chk("rs_addr",  int'(bif.mem_addr), 0);
        chk("rs_wdata", int'(bif.mem_wdata), 0);
        chk("rs_busy",  int'(bif.busy), 0);
        chk("rs_done",  int'(bif.strip_done), 0);
        chk("rs_ready", int'(bif.in_ready), 0);
        wr0 = n_wr;
        repeat (20) tick();
        chk("rs_nowr", n_wr - wr0, 0);
        clear_mon();
        run_strip(0, 0, 0, 1 << 30, lat, p);
        chk("rs_seq", seq_err, 0);
        chk("rs_nwr", n_wr, 8772);
        chk("rs_img", bad_count(0), 0);
        bif.in_valid = 1'b0;

        // Small instance: 4x2 raw, 6x4 padded.
        s_nwr = 0;
        sp = 0;
        scyc = 0;
        sif.in_valid = 1'b1;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        while (scyc < 200 && !sif.strip_done) begin
            sif.in_data = 8'(8'h10 + sp);
            @(negedge clk);
            mon();
            srdy = sif.in_ready;
            @(posedge clk);
            #2;
            if (srdy && sif.in_valid) sp++;
            scyc++;
        end
        sif.in_valid = 1'b0;
        chk("sm_timeout", int'(scyc < 200), 1);
        chk("sm_nwr", s_nwr, 24);
        chk("sm_a7", int'(s_img[7]), 8'h10);
        chk("sm_a16", int'(s_img[16]), 8'h17);
        s_bad = 0;
        for (int a = 0; a < 24; a++) begin
            logic [7:0] e;
            if (a >= 7 && a <= 10)       e = 8'(8'h10 + a - 7);
            else if (a >= 13 && a <= 16) e = 8'(8'h14 + a - 13);
            else                         e = 8'h00;
            if (s_img[a] !== e) s_bad++;
        end
        chk("sm_img", s_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
